// File: rtl/switch_pkg.sv
// Shared types for the switch output-port slice.
//   DEPTH_DEF   : default packet-buffer depth (bytes)
//   out_state_e : read-side FSM states
//   buf_entry_t : one buffered byte tagged with its end-of-packet flag
package switch_pkg;
  localparam int DEPTH_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } out_state_e;

  typedef struct packed {
    logic       eop;
    logic [7:0] data;
  } buf_entry_t;
endpackage

// File: rtl/pkt_fifo.sv
// Synchronous FIFO of buf_entry_t with first-word-fall-through head.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   i_push/i_wdata : write an entry (ignored when full)
//   i_pop          : drop the head entry (ignored when empty)
//   o_head         : current head entry, valid whenever !o_empty
//   o_empty        : no entries stored
//   o_count        : occupancy, 0..DEPTH
module pkt_fifo
  import switch_pkg::*;
#(
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_push,
  input  buf_entry_t        i_wdata,
  input  logic              i_pop,
  output buf_entry_t        o_head,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count
);
  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  buf_entry_t        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;

  logic w_push;
  logic w_pop;

  assign w_push  = i_push && (r_count != FULL_CNT);
  assign w_pop   = i_pop  && (r_count != '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // Storage carries no reset; occupancy and pointers define what is live.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers are exactly ADDR_W bits so they wrap modulo DEPTH for free.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/switch_out_port.sv
// Output-port stage: buffers routed bytes and hands whole packets to the
// external reader over the port/ready/read handshake.
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   in_data/in_valid/in_eop, in_ready : byte stream from the switch core
//   port, ready, read : reader interface (byte, packet-available, advance)
//   pkt_count         : number of complete packets held in the buffer
module switch_out_port
  import switch_pkg::*;
#(
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_eop,
  output logic              in_ready,
  output logic [7:0]        port,
  output logic              ready,
  input  logic              read,
  output logic [ADDR_W:0]   pkt_count
);
  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  out_state_e      r_state;
  out_state_e      w_state_nxt;
  logic [7:0]      r_port;
  logic            r_cur_eop;
  logic [ADDR_W:0] r_pkt_count;

  buf_entry_t      w_head;
  buf_entry_t      w_wdata;
  logic            w_empty;
  logic [ADDR_W:0] w_count;
  logic            w_push;
  logic            w_pop;
  logic            w_load;
  logic            w_clr;
  logic            w_inc;
  logic            w_dec;
  logic            w_ready;

  // in_ready depends only on buffer occupancy, never on in_valid.
  assign in_ready = (w_count != FULL_CNT);
  assign w_push   = in_valid && in_ready;
  assign w_wdata  = '{eop: in_eop, data: in_data};
  assign w_inc    = w_push && in_eop;

  pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Only complete packets start a transfer, so the head is always present
  // while in SEND; the !w_empty term in IDLE is purely defensive.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_clr       = 1'b0;
    w_dec       = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = (r_pkt_count != '0);
        if (w_ready && read && !w_empty) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        w_ready = 1'b1;
        if (read) begin
          if (r_cur_eop) begin
            w_clr       = 1'b1;
            w_dec       = 1'b1;
            w_state_nxt = GAP;
          end else begin
            w_pop  = 1'b1;
            w_load = 1'b1;
          end
        end
      end
      GAP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_cur_eop remembers whether the byte now on port closes the packet.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_port      <= '0;
      r_cur_eop   <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      if (w_load) begin
        r_port    <= w_head.data;
        r_cur_eop <= w_head.eop;
      end else if (w_clr) begin
        r_port    <= '0;
        r_cur_eop <= 1'b0;
      end
      // An eop arriving on the edge the previous packet finishes nets to zero.
      case ({w_inc, w_dec})
        2'b10:   r_pkt_count <= r_pkt_count + 1'b1;
        2'b01:   r_pkt_count <= r_pkt_count - 1'b1;
        default: r_pkt_count <= r_pkt_count;
      endcase
    end
  end

  assign port      = r_port;
  assign ready     = w_ready;
  assign pkt_count = r_pkt_count;
endmodule

// File: tb/tb_switch_out_port.sv
module tb_switch_out_port;
  import switch_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clock    = 1'b0;
  logic          reset    = 1'b1;
  logic [7:0]    in_data  = '0;
  logic          in_valid = 1'b0;
  logic          in_eop   = 1'b0;
  logic          read     = 1'b0;
  logic          in_ready;
  logic [7:0]    port;
  logic          ready;
  logic [AW:0]   pkt_count;

  int n_chk = 0;
  int n_err = 0;
  logic [8:0] sb_q[$];   // {eop, data} in expected delivery order
  logic mon_active = 1'b0;

  switch_out_port #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_eop    (in_eop),
    .in_ready  (in_ready),
    .port      (port),
    .ready     (ready),
    .read      (read),
    .pkt_count (pkt_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Oversized packet would wedge the writer with nothing to read.
  always @(negedge clock) begin
    if (!reset)
      assert (!(!in_ready && pkt_count == '0 && dut.r_state == IDLE))
        else $error("writer stalled with no complete packet buffered");
  end

  // Output monitor: a byte on port is consumed at the next edge when read=1.
  always @(negedge clock) begin
    logic [8:0] e;
    if (reset) begin
      sb_q.delete();
      mon_active = 1'b0;
    end else if (!mon_active) begin
      chk("port_idle", {24'd0, port}, 32'd0);
      if (ready && read) mon_active = 1'b1;
    end else begin
      chk("ready_send", {31'd0, ready}, 32'd1);
      if (sb_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL sb_empty: port=%0h but no byte expected", port);
      end else begin
        chk("port_data", {24'd0, port}, {24'd0, sb_q[0][7:0]});
        if (read) begin
          e = sb_q.pop_front();
          if (e[8]) mon_active = 1'b0;
        end
      end
    end
  end

  task automatic wr_byte(input logic [7:0] d, input logic e);
    int t = 0;
    bit ok = 0;
    in_data = d; in_eop = e; in_valid = 1'b1;
    while (!ok && t < 200) begin
      @(negedge clock);
      if (in_ready) ok = 1; else t++;
    end
    if (!ok) begin
      n_chk++;
      n_err++;
      $display("FAIL wr_timeout: in_ready=%0b expected 1", in_ready);
      in_valid = 1'b0; in_eop = 1'b0;
      return;
    end
    @(posedge clock); #1;
    sb_q.push_back({e, d});
    in_valid = 1'b0; in_eop = 1'b0;
  endtask

  task automatic wr_pkt(input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++)
      wr_byte(base + i[7:0], (i == len - 1));
  endtask

  // Wait for the last expected byte to be consumed, then check the GAP cycle.
  task automatic drain(input string tag);
    int t = 0;
    while (sb_q.size() != 0 && t < 500) begin
      @(posedge clock);
      t++;
    end
    #1;
    if (sb_q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_timeout: %0d bytes left expected 0", tag, sb_q.size());
    end
    @(negedge clock);
    chk({tag, "_gap_ready"}, {31'd0, ready}, 32'd0);
    chk({tag, "_pkt_count"}, {25'd0, pkt_count}, 32'd0);
  endtask

  initial begin
    int exp_rdy [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int exp_pkt [10] = '{2, 2, 2, 2, 1, 1, 1, 1, 1, 0};

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_port",     {24'd0, port},      32'd0);
    chk("rst_ready",    {31'd0, ready},     32'd0);
    chk("rst_in_ready", {31'd0, in_ready},  32'd1);
    chk("rst_pkt",      {25'd0, pkt_count}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // 1: single 4-byte packet, read held high
    read = 1'b1;
    wr_byte(8'h01, 1'b0);
    wr_byte(8'h02, 1'b0);
    wr_byte(8'h03, 1'b0);
    wr_byte(8'hAA, 1'b1);
    @(negedge clock);
    chk("t1_ready_lat", {31'd0, ready},     32'd1);
    chk("t1_pkt",       {25'd0, pkt_count}, 32'd1);
    drain("t1");

    // 2: two pre-loaded packets, cycle-exact ready/pkt_count
    @(posedge clock); #1;
    read = 1'b0;
    wr_pkt(3, 8'h10);
    wr_pkt(3, 8'h20);
    read = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      chk("t2_ready", {31'd0, ready},     exp_rdy[c]);
      chk("t2_pkt",   {25'd0, pkt_count}, exp_pkt[c]);
    end
    chk("t2_sb", sb_q.size(), 32'd0);

    // 3: mid-packet stall after the second byte
    @(posedge clock); #1;
    read = 1'b0;
    wr_pkt(5, 8'h30);
    read = 1'b1;
    @(posedge clock);
    @(posedge clock); #1;
    read = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("t3_hold", {24'd0, port}, 32'h31);
    end
    @(posedge clock); #1;
    read = 1'b1;
    drain("t3");

    // 4: fill the buffer with one DEPTH-byte packet
    @(posedge clock); #1;
    read = 1'b0;
    wr_pkt(DEPTH, 8'h80);
    @(negedge clock);
    chk("t4_full",     {31'd0, in_ready},  32'd0);
    chk("t4_pkt",      {25'd0, pkt_count}, 32'd1);
    @(posedge clock); #1;
    read = 1'b1;
    @(negedge clock);
    chk("t4_full_pre", {31'd0, in_ready},  32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("t4_freed",    {31'd0, in_ready},  32'd1);
    drain("t4");

    // 5: eop of B lands on the edge A's last byte is consumed
    @(posedge clock); #1;
    read = 1'b0;
    wr_pkt(3, 8'h40);
    wr_byte(8'h50, 1'b0);
    wr_byte(8'h51, 1'b0);
    read = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    in_data = 8'h52; in_eop = 1'b1; in_valid = 1'b1;
    @(negedge clock);
    chk("t5_pkt_pre",  {25'd0, pkt_count}, 32'd1);
    chk("t5_in_ready", {31'd0, in_ready},  32'd1);
    @(posedge clock); #1;
    sb_q.push_back({1'b1, 8'h52});
    in_valid = 1'b0; in_eop = 1'b0;
    @(negedge clock);
    chk("t5_pkt_same", {25'd0, pkt_count}, 32'd1);
    chk("t5_gap",      {31'd0, ready},     32'd0);
    @(negedge clock);
    chk("t5_reready",  {31'd0, ready},     32'd1);
    drain("t5");

    // 6: reset during SEND, then a fresh packet
    @(posedge clock); #1;
    read = 1'b0;
    wr_pkt(6, 8'h60);
    read = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("t6_ready",    {31'd0, ready},     32'd0);
    chk("t6_port",     {24'd0, port},      32'd0);
    chk("t6_pkt",      {25'd0, pkt_count}, 32'd0);
    chk("t6_in_ready", {31'd0, in_ready},  32'd1);
    @(posedge clock); #1;
    wr_pkt(2, 8'h70);
    drain("t6");

    chk("sb_final", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1, "timeout");
  end
endmodule
